// File: rtl/regtmp_sched.sv
// regtmp_sched: sequencing controller for the temporary (speculative) register file.
// It allocates entries in circular order, arbitrates two CDB writers onto the single
// write port, and retires entries in order through the commit interface.
// Optional build macro: REGTMP_SCHED_TAG_CHECK_EN. When it is defined, CDB updates
// whose tag lies outside the occupied window are handshaken but not written, and the
// err_stale output pulses for one cycle.
module regtmp_sched #(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  // dispatch allocation
  input  logic             alloc_req,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  input  logic [1:0]       alloc_type,
  output logic             alloc_ack,
  output logic [PTR_W-1:0] alloc_tag,
  // completion buses
  input  logic             cdb0_req,
  input  logic [PTR_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_data,
  output logic             cdb0_gnt,
  input  logic             cdb1_req,
  input  logic [PTR_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_data,
  output logic             cdb1_gnt,
  // temp-file ports
  output logic [4:0]       rf_waddr,
  output logic [72:0]      rf_data_in,
  output logic             rf_new_entry,
  output logic             rf_update_entry,
  output logic [4:0]       rf_rd_addr1,
  input  logic [72:0]      rf_data_out1,
  // retire interface
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_data,
  output logic [31:0]      commit_pc,
  output logic             empty,
  output logic             full
`ifdef REGTMP_SCHED_TAG_CHECK_EN
  ,
  output logic             err_stale
`endif
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [0:0]       state_reg;
  logic             rr_reg;

  logic             commit_valid_reg;
  logic [4:0]       commit_rd_reg;
  logic [31:0]      commit_data_reg;
  logic [31:0]      commit_pc_reg;

  logic             run_ok;
  logic             cdb_gnt;
  logic             cdb_upd;
  logic             contested;
  logic             commit_fire;
  logic [PTR_W-1:0] cdb_tag_sel;
  logic [31:0]      cdb_data_sel;
  logic [1:0]       unused_type_bits;

  // Nothing is granted, acknowledged or retired while in reset, during a flush
  // cycle, or in the single recovery cycle that follows it.
  assign run_ok = (state_reg == ST_RUN) && !flush && !reset;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));

  // Round-robin between the two completion buses; a lone requester always wins.
  assign cdb0_gnt     = run_ok && cdb0_req && (!cdb1_req || !rr_reg);
  assign cdb1_gnt     = run_ok && cdb1_req && (!cdb0_req ||  rr_reg);
  assign cdb_gnt      = cdb0_gnt || cdb1_gnt;
  assign contested    = run_ok && cdb0_req && cdb1_req;
  assign cdb_tag_sel  = cdb1_gnt ? cdb1_tag  : cdb0_tag;
  assign cdb_data_sel = cdb1_gnt ? cdb1_data : cdb0_data;

`ifdef REGTMP_SCHED_TAG_CHECK_EN
  logic [PTR_W-1:0] tag_offset;
  logic             tag_in_window;
  logic             err_stale_reg;

  // Distance from head modulo DEPTH; inside the window when below the occupancy.
  assign tag_offset    = cdb_tag_sel - head_reg;
  assign tag_in_window = ({1'b0, tag_offset} < count_reg);
  assign cdb_upd       = cdb_gnt && tag_in_window;
  assign err_stale     = err_stale_reg;

  // One-cycle pulse for a granted update that targets an unoccupied entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_stale_reg <= 1'b0;
    end else begin
      err_stale_reg <= cdb_gnt && !tag_in_window;
    end
  end
`else
  assign cdb_upd = cdb_gnt;
`endif

  // Completion traffic has priority over dispatch on the shared write port.
  assign alloc_ack   = alloc_req && !full && !cdb_gnt && run_ok;
  assign alloc_tag   = tail_reg;
  assign rf_rd_addr1 = 5'(head_reg);

  // The head entry retires once it is both allocated and carries a result.
  assign commit_fire = run_ok && (count_reg != '0) && rf_data_out1[0] && rf_data_out1[1];

  // The instruction type is not part of the retire payload.
  assign unused_type_bits = rf_data_out1[35:34];

  assign head_next  = head_reg + PTR_W'(commit_fire);
  assign tail_next  = tail_reg + PTR_W'(alloc_ack);
  assign count_next = count_reg + (PTR_W+1)'(alloc_ack) - (PTR_W+1)'(commit_fire);

  assign commit_valid = commit_valid_reg;
  assign commit_rd    = commit_rd_reg;
  assign commit_data  = commit_data_reg;
  assign commit_pc    = commit_pc_reg;

  // Single write port: either a result update or a fresh entry, never both.
  always_comb begin
    rf_waddr        = '0;
    rf_data_in      = '0;
    rf_new_entry    = 1'b0;
    rf_update_entry = 1'b0;
    if (cdb_upd) begin
      rf_update_entry = 1'b1;
      rf_waddr        = 5'(cdb_tag_sel);
      rf_data_in      = {5'd0, 32'd0, 2'd0, cdb_data_sel, 1'b1, 1'b0};
    end else if (alloc_ack) begin
      rf_new_entry = 1'b1;
      rf_waddr     = 5'(tail_reg);
      rf_data_in   = {alloc_rd, alloc_pc, alloc_type, 32'd0, 1'b0, 1'b1};
    end
  end

  // Pointers, occupancy, flush FSM and arbitration fairness bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= ST_RUN;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= flush ? ST_FLUSH : ST_RUN;
      if (contested) begin
        rr_reg <= !rr_reg;
      end
      if (flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_next;
        tail_reg  <= tail_next;
        count_reg <= count_next;
      end
    end
  end

  // Retire register: captures the head entry fields on the cycle it fires.
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_valid_reg <= 1'b0;
      commit_rd_reg    <= '0;
      commit_data_reg  <= '0;
      commit_pc_reg    <= '0;
    end else begin
      commit_valid_reg <= commit_fire;
      if (commit_fire) begin
        commit_rd_reg   <= rf_data_out1[72:68];
        commit_pc_reg   <= rf_data_out1[67:36];
        commit_data_reg <= rf_data_out1[33:2];
      end
    end
  end

endmodule
